// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the sequential ROM instruction prefetcher.
package rom_fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_entry_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ROM_WORDS  = 256;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rom_fetch_buf_fifo.sv
// Small synchronous FIFO of fetch entries with flush; the head is readable combinationally.
module fetch_fifo
    import rom_fetch_pkg::*;
#(
    parameter  int unsigned Depth = 4,
    localparam int unsigned AW    = $clog2(Depth)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [AW:0]  count_o
);

    localparam logic [AW:0] DepthC = Depth[AW:0];

    fetch_entry_t   mem_q [Depth];
    logic [AW-1:0]  wptr_q, rptr_q;
    logic [AW:0]    count_q;
    logic           pop_ok;

    assign pop_ok  = pop_i & (count_q != '0);
    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= entry_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop_ok) rptr_q <= rptr_q + 1'b1;
            case ({push_i, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= DepthC);

endmodule

// File: rtl/rom_fetch_buf.sv
// Sequential prefetcher between the core fetch port and a 1-cycle-latency ROM.
// Define ROM_FETCH_ERR_EN to add err_o, flagging misaligned or out-of-ROM branch targets.
module rom_fetch_buf
    import rom_fetch_pkg::*;
#(
    parameter int unsigned Depth    = 4,
    parameter logic [31:0] BootAddr = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
`ifdef ROM_FETCH_ERR_EN
    output logic        err_o,
`endif
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned AW     = $clog2(Depth);
    localparam logic [AW:0] DepthC = Depth[AW:0];

    fetch_state_e state_q;
    logic [31:0]  fetch_addr_q;
    logic [31:0]  inflight_addr_q;
    logic         inflight_q;

    logic [AW:0]  count;
    logic [AW:0]  occ;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         issue, push, pop;

    // Space check counts the outstanding read so a response can never overflow the FIFO.
    assign occ   = count + {{AW{1'b0}}, inflight_q};
    assign issue = (state_q == RUN) & ~branch_i & (occ < DepthC);
    assign push  = mem_rvalid_i & inflight_q & ~branch_i;
    assign pop   = valid_o & ready_i & ~branch_i;

    assign push_entry = '{addr: inflight_addr_q, data: mem_rdata_i};

    fetch_fifo #(.Depth(Depth)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .flush_i (branch_i),
        .head_o  (head),
        .count_o (count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            fetch_addr_q    <= word_align(BootAddr);
            inflight_addr_q <= '0;
            inflight_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_i)  state_q <= RUN;
                RUN:  if (!req_i) state_q <= IDLE;
            endcase
            inflight_q <= issue;
            if (issue) inflight_addr_q <= fetch_addr_q;
            if (branch_i)   fetch_addr_q <= word_align(branch_addr_i);
            else if (issue) fetch_addr_q <= fetch_addr_q + 32'(WORD_BYTES);
        end
    end

    assign valid_o     = (count != '0);
    assign rdata_o     = head.data;
    assign addr_o      = head.addr;
    assign mem_req_o   = issue;
    assign mem_addr_o  = fetch_addr_q;
    assign mem_we_o    = 1'b0;
    assign mem_be_o    = 4'hF;
    assign mem_wdata_o = '0;

`ifdef ROM_FETCH_ERR_EN
    logic err_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= branch_i & ((branch_addr_i[1:0] != 2'b00) |
                              ({2'b00, branch_addr_i[31:2]} >= 32'(ROM_WORDS)));
    end
    assign err_o = err_q;
`endif

    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i |-> inflight_q);

endmodule

// File: tb/tb_rom_fetch_buf.sv
// Randomized bench for rom_fetch_buf against a queue-based reference of the fetch stream.
module tb_rom_fetch_buf;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BOOT  = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0, branch_i = 1'b0, ready_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        valid_o, mem_req_o, mem_we_o;
    logic [31:0] rdata_o, addr_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
`ifdef ROM_FETCH_ERR_EN
    logic        err_o;
`endif

    rom_fetch_buf #(.Depth(DEPTH), .BootAddr(BOOT)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .rdata_o       (rdata_o),
        .addr_o        (addr_o),
`ifdef ROM_FETCH_ERR_EN
        .err_o         (err_o),
`endif
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + {24'h0, a[9:2]};
    endfunction

    // ROM: answers every request one cycle later
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_rvalid_i <= 1'b0;
            mem_rdata_i  <= '0;
        end else begin
            mem_rvalid_i <= mem_req_o;
            mem_rdata_i  <= rom_word(mem_addr_o);
        end
    end

    // Scoreboard
    int          n_vec = 0;
    int          n_err = 0;
    int          n_issue = 0;
    logic [31:0] exp_q[$];
    logic        m_run, m_inflight, m_err;
    logic [31:0] m_fetch, m_inaddr;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_run      = 1'b0;
        m_inflight = 1'b0;
        m_err      = 1'b0;
        m_fetch    = {BOOT[31:2], 2'b00};
        m_inaddr   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; req_i = 1'b0; branch_i = 1'b0; ready_i = 1'b0; branch_addr_i = '0;
        #1;
        check_eq("rst_valid", {31'h0, valid_o}, 32'h0);
        check_eq("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
        check_eq("rst_addr", addr_o, 32'h0);
        check_eq("rst_rdata", rdata_o, 32'h0);
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // One clock of stimulus; compares outputs, then advances the reference.
    task automatic cycle(input logic req, input logic br, input logic [31:0] ba, input logic rdy);
        logic exp_valid, exp_req;
        @(negedge clk_i);
        req_i = req; branch_i = br; branch_addr_i = ba; ready_i = rdy;
        #1;
        exp_valid = (exp_q.size() != 0);
        exp_req   = m_run && !br && ((exp_q.size() + int'(m_inflight)) < DEPTH);
        check_eq("valid", {31'h0, valid_o}, {31'h0, exp_valid});
        check_eq("mem_req", {31'h0, mem_req_o}, {31'h0, exp_req});
        if (exp_req) check_eq("mem_addr", mem_addr_o, m_fetch);
        if (exp_valid) begin
            check_eq("head_addr", addr_o, exp_q[0]);
            check_eq("head_data", rdata_o, rom_word(exp_q[0]));
        end
`ifdef ROM_FETCH_ERR_EN
        check_eq("err", {31'h0, err_o}, {31'h0, m_err});
        m_err = br && ((ba[1:0] != 2'b00) || (ba >= 32'h400));
`endif
        if (mem_req_o) n_issue++;
        if (br) begin
            exp_q.delete();
            m_fetch = {ba[31:2], 2'b00};
        end else begin
            if (exp_valid && rdy) void'(exp_q.pop_front());
            if (m_inflight) exp_q.push_back(m_inaddr);
        end
        m_inflight = exp_req;
        if (exp_req) begin
            m_inaddr = m_fetch;
            m_fetch  = m_fetch + 32'd4;
        end
        m_run = req;
    endtask

    initial begin
        model_reset();
        do_reset();
        check_eq("mem_we", {31'h0, mem_we_o}, 32'h0);
        check_eq("mem_be", {28'h0, mem_be_o}, 32'hF);
        check_eq("mem_wdata", mem_wdata_o, 32'h0);

        // Streaming from boot
        repeat (10) cycle(1'b1, 1'b0, '0, 1'b1);

        // Stalled core: exactly DEPTH reads, then resume
        do_reset();
        n_issue = 0;
        repeat (12) cycle(1'b1, 1'b0, '0, 1'b0);
        check_eq("stall_issues", 32'(n_issue), 32'(DEPTH));
        repeat (8) cycle(1'b1, 1'b0, '0, 1'b1);

        // Branch with full FIFO
        repeat (8) cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 32'h40, 1'b0);
        repeat (8) cycle(1'b1, 1'b0, '0, 1'b1);

        // Branch while a response is arriving, then a misaligned target
        cycle(1'b1, 1'b1, 32'h80, 1'b1);
        repeat (6) cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b1, 32'h42, 1'b1);
        repeat (6) cycle(1'b1, 1'b0, '0, 1'b1);

        // Drop req with words buffered and one in flight, drain, resume
        do_reset();
        repeat (3) cycle(1'b1, 1'b0, '0, 1'b0);
        n_issue = 0;
        repeat (4) cycle(1'b0, 1'b0, '0, 1'b0);
        repeat (6) cycle(1'b0, 1'b0, '0, 1'b1);
        check_eq("idle_issues", 32'(n_issue), 32'h1);
        repeat (8) cycle(1'b1, 1'b0, '0, 1'b1);

        // Address wrap at the top of the space
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (8) cycle(1'b1, 1'b0, '0, 1'b1);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            logic        r, b, y;
            logic [31:0] a;
            if (k % 150 == 149) do_reset();
            r = ($urandom_range(0, 9) != 0);
            b = ($urandom_range(0, 15) == 0);
            y = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            cycle(r, b, a, y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
